// File: rtl/load_store_unit.sv
// Load/store engine that turns one core access into one or two bus beats with byte strobes.
// Handles wait states, optional misaligned splitting, load extension and a per-beat bus timeout.
module load_store_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_error,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int CNTW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP, S_ERR} state_e;

    state_e                  state_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    split_q;
    logic [CNTW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0]   rbuf_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [LANES-1:0]        mem_wstrb_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    resp_valid_q;
    logic                    resp_error_q;
    logic [31:0]             resp_rdata_q;

    // Beat geometry is derived from the live request while idle, from the latched copy afterwards.
    logic [ADDR_WIDTH-1:0]   src_addr;
    logic [1:0]              src_size;
    logic [31:0]             src_wdata;
    logic [OFFW-1:0]         src_off;
    logic [3:0]              base_strb;
    logic [31:0]             wmask_data;
    logic [2*LANES-1:0]      strb_wide;
    logic [2*DATA_WIDTH-1:0] data_wide;
    logic [ADDR_WIDTH-1:0]   beat0_addr;
    logic                    misaligned;
    logic                    bad_req;
    logic [2*DATA_WIDTH-1:0] rd_cat;
    logic [31:0]             rd_raw;
    logic [31:0]             rd_ext;
    logic                    tmo_hit;

    assign src_addr   = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign src_size   = (state_q == S_IDLE) ? req_size  : size_q;
    assign src_wdata  = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign src_off    = src_addr[OFFW-1:0];
    assign beat0_addr = {src_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

    always_comb begin
        base_strb  = 4'hF;
        wmask_data = src_wdata;
        case (src_size)
            2'd0: begin
                base_strb  = 4'h1;
                wmask_data = {24'd0, src_wdata[7:0]};
            end
            2'd1: begin
                base_strb  = 4'h3;
                wmask_data = {16'd0, src_wdata[15:0]};
            end
            default: ;
        endcase
    end

    // Upper half of the wide vectors is what spills into the second beat.
    assign strb_wide = (2*LANES)'(base_strb) << src_off;
    assign data_wide = (2*DATA_WIDTH)'(wmask_data) << {src_off, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign bad_req = (req_size == 2'd3) || (!ALLOW_MISALIGNED && misaligned);

    assign rd_cat = (state_q == S_BEAT1) ? {mem_rdata, rbuf_q}
                                         : {{DATA_WIDTH{1'b0}}, mem_rdata};
    assign rd_raw = 32'(rd_cat >> {addr_q[OFFW-1:0], 3'b000});

    always_comb begin
        rd_ext = rd_raw;
        case (size_q)
            2'd0: rd_ext = unsigned_q ? {24'd0, rd_raw[7:0]}  : {{24{rd_raw[7]}}, rd_raw[7:0]};
            2'd1: rd_ext = unsigned_q ? {16'd0, rd_raw[15:0]} : {{16{rd_raw[15]}}, rd_raw[15:0]};
            default: ;
        endcase
    end

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            split_q      <= 1'b0;
            cnt_q        <= '0;
            rbuf_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        if (bad_req) begin
                            state_q      <= S_ERR;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else begin
                            state_q     <= S_BEAT0;
                            cnt_q       <= '0;
                            split_q     <= |strb_wide[2*LANES-1:LANES];
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= beat0_addr;
                            mem_wstrb_q <= strb_wide[LANES-1:0];
                            mem_wdata_q <= data_wide[DATA_WIDTH-1:0];
                        end
                    end
                end
                S_BEAT0, S_BEAT1: begin
                    if (mem_ack) begin
                        cnt_q <= '0;
                        if (state_q == S_BEAT0 && split_q) begin
                            state_q     <= S_BEAT1;
                            rbuf_q      <= mem_rdata;
                            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(LANES);
                            mem_wstrb_q <= strb_wide[2*LANES-1:LANES];
                            mem_wdata_q <= data_wide[2*DATA_WIDTH-1:DATA_WIDTH];
                        end else begin
                            state_q      <= S_RESP;
                            mem_req_q    <= 1'b0;
                            mem_we_q     <= 1'b0;
                            mem_addr_q   <= '0;
                            mem_wstrb_q  <= '0;
                            mem_wdata_q  <= '0;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= write_q ? 32'd0 : rd_ext;
                        end
                    end else if (tmo_hit) begin
                        // An ack in the final cycle is taken above, so it wins over the timeout.
                        state_q      <= S_ERR;
                        cnt_q        <= '0;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wstrb_q  <= '0;
                        mem_wdata_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP, S_ERR: state_q <= S_IDLE;
                default:       state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;

endmodule
